// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-aware round-robin arbiter: N AXI-Stream sources onto one sink through a 2-entry output slice.
// Latency: 1 cycle input->output, 1 idle arbitration cycle per packet; upstream ready drops while the skid entry is occupied.
module axis_rr_pkt_arbiter #(
    parameter int P_NUM_PORTS  = 4,
    parameter int P_DATA_WIDTH = 16,
    parameter int P_ID_WIDTH   = ($clog2(P_NUM_PORTS) > 0 ? $clog2(P_NUM_PORTS) : 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_NUM_PORTS-1:0]              s_axis_tvalid,
    output logic [P_NUM_PORTS-1:0]              s_axis_tready,
    input  logic [P_NUM_PORTS*P_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [P_NUM_PORTS-1:0]              s_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [P_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                                m_axis_tlast,
    output logic [P_ID_WIDTH-1:0]               m_axis_tid,
    output logic                                grant_active,
    output logic [P_ID_WIDTH-1:0]               grant_id,
    output logic [15:0]                         pkt_count
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PASS = 1'b1;
    localparam logic [P_ID_WIDTH-1:0] LP_LAST_ID = P_ID_WIDTH'(P_NUM_PORTS - 1);

    logic [0:0]              state_q, state_d;
    logic [P_ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [P_ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [15:0]             pkt_count_q, pkt_count_d;
    logic                    main_vld_q, main_vld_d;
    logic [P_DATA_WIDTH-1:0] main_dat_q, main_dat_d;
    logic                    main_last_q, main_last_d;
    logic [P_ID_WIDTH-1:0]   main_tid_q, main_tid_d;
    logic                    skid_vld_q, skid_vld_d;
    logic [P_DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic                    skid_last_q, skid_last_d;
    logic [P_ID_WIDTH-1:0]   skid_tid_q, skid_tid_d;

    logic                    found;
    logic [P_ID_WIDTH-1:0]   sel;
    logic                    in_vld;
    logic [P_DATA_WIDTH-1:0] in_dat;
    logic                    in_last;
    logic                    rdy_ok;
    logic                    accept;
    logic                    main_hs;

    // Rotating priority: ports above last_grant first, then wrap to port 0.
    always_comb begin
        found = 1'b0;
        sel   = last_grant_q;
        for (int j = 0; j < P_NUM_PORTS; j++) begin
            if (!found && s_axis_tvalid[j] && (j > int'(last_grant_q))) begin
                found = 1'b1;
                sel   = P_ID_WIDTH'(j);
            end
        end
        for (int j = 0; j < P_NUM_PORTS; j++) begin
            if (!found && s_axis_tvalid[j] && (j <= int'(last_grant_q))) begin
                found = 1'b1;
                sel   = P_ID_WIDTH'(j);
            end
        end
    end

    always_comb begin
        in_vld  = 1'b0;
        in_dat  = '0;
        in_last = 1'b0;
        for (int j = 0; j < P_NUM_PORTS; j++) begin
            if (grant_id_q == P_ID_WIDTH'(j)) begin
                in_vld  = s_axis_tvalid[j];
                in_dat  = s_axis_tdata[j*P_DATA_WIDTH +: P_DATA_WIDTH];
                in_last = s_axis_tlast[j];
            end
        end
    end

    assign rdy_ok  = (state_q == S_PASS) && !skid_vld_q;
    assign accept  = rdy_ok && in_vld;
    assign main_hs = main_vld_q && m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        for (int j = 0; j < P_NUM_PORTS; j++) begin
            s_axis_tready[j] = rdy_ok && (grant_id_q == P_ID_WIDTH'(j));
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_id_d = sel;
                    state_d    = S_PASS;
                end
            end
            default: begin
                if (accept && in_last) begin
                    state_d      = S_IDLE;
                    last_grant_d = grant_id_q;
                    pkt_count_d  = pkt_count_q + 16'd1;
                end
            end
        endcase
    end

    // Skid drains into main first; the input cannot be accepted while skid holds a beat.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_dat_d  = main_dat_q;
        main_last_d = main_last_q;
        main_tid_d  = main_tid_q;
        skid_vld_d  = skid_vld_q;
        skid_dat_d  = skid_dat_q;
        skid_last_d = skid_last_q;
        skid_tid_d  = skid_tid_q;
        if (main_hs && skid_vld_q) begin
            main_vld_d  = 1'b1;
            main_dat_d  = skid_dat_q;
            main_last_d = skid_last_q;
            main_tid_d  = skid_tid_q;
            skid_vld_d  = 1'b0;
        end else if (accept) begin
            if (!main_vld_q || main_hs) begin
                main_vld_d  = 1'b1;
                main_dat_d  = in_dat;
                main_last_d = in_last;
                main_tid_d  = grant_id_q;
            end else begin
                skid_vld_d  = 1'b1;
                skid_dat_d  = in_dat;
                skid_last_d = in_last;
                skid_tid_d  = grant_id_q;
            end
        end else if (main_hs) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_id_q   <= LP_LAST_ID;
            last_grant_q <= LP_LAST_ID;
            pkt_count_q  <= '0;
            main_vld_q   <= 1'b0;
            main_dat_q   <= '0;
            main_last_q  <= 1'b0;
            main_tid_q   <= '0;
            skid_vld_q   <= 1'b0;
            skid_dat_q   <= '0;
            skid_last_q  <= 1'b0;
            skid_tid_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
            main_vld_q   <= main_vld_d;
            main_dat_q   <= main_dat_d;
            main_last_q  <= main_last_d;
            main_tid_q   <= main_tid_d;
            skid_vld_q   <= skid_vld_d;
            skid_dat_q   <= skid_dat_d;
            skid_last_q  <= skid_last_d;
            skid_tid_q   <= skid_tid_d;
        end
    end

    assign m_axis_tvalid = main_vld_q;
    assign m_axis_tdata  = main_dat_q;
    assign m_axis_tlast  = main_last_q;
    assign m_axis_tid    = main_tid_q;
    assign grant_active  = (state_q == S_PASS);
    assign grant_id      = grant_id_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Bench for axis_rr_pkt_arbiter: cycle vector table, directed corner sequences, randomized traffic vs a packet-order model.
module tb_axis_rr_pkt_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tready;
    logic [3:0]  s_tlast = '0;
    logic [15:0] s_dat [4];
    logic [63:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic [1:0]  m_tid;
    logic        grant_active;
    logic [1:0]  grant_id;
    logic [15:0] pkt_count;

    assign s_tdata = {s_dat[3], s_dat[2], s_dat[1], s_dat[0]};

    axis_rr_pkt_arbiter #(.P_NUM_PORTS(4), .P_DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .grant_active(grant_active), .grant_id(grant_id), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] dat;
        logic        last;
        logic [1:0]  tid;
        int          cyc;
    } beat_t;

    beat_t       mon_q[$];
    bit          mon_en = 1'b0;
    int          cyc_cnt = 0;
    logic        stall_q = 1'b0;
    logic [18:0] stall_val = '0;

    // Output monitor: collects handshaken beats and enforces hold-while-stalled.
    always @(negedge clk) begin
        cyc_cnt++;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("stall_vld", 32'(m_tvalid), 32'd1);
                chk("stall_hold", 32'({m_tlast, m_tid, m_tdata}), 32'(stall_val));
            end
            stall_q   = m_tvalid && !m_tready;
            stall_val = {m_tlast, m_tid, m_tdata};
            if (mon_en && m_tvalid && m_tready)
                mon_q.push_back('{m_tdata, m_tlast, m_tid, cyc_cnt});
        end
    end

    task automatic clear_inputs();
        s_tvalid = '0;
        s_tlast  = '0;
        for (int p = 0; p < 4; p++) s_dat[p] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_beat(input int p, input logic [15:0] d, input logic l);
        int   n = 0;
        logic got = 1'b0;
        s_tvalid[p[1:0]] = 1'b1;
        s_dat[p[1:0]]    = d;
        s_tlast[p[1:0]]  = l;
        while (!got && n < 50) begin
            @(negedge clk);
            chk("other_rdy", 32'(s_tready & ~(4'b0001 << p)), 32'd0);
            got = s_tready[p[1:0]];
            @(posedge clk); #1;
            n++;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        s_tvalid[p[1:0]] = 1'b0;
        s_tlast[p[1:0]]  = 1'b0;
    endtask

    task automatic drain_and_check(input logic [15:0] ed[], input logic [1:0] et[], input string nm);
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b0;
        chk({nm, "_count"}, 32'(mon_q.size()), 32'(ed.size()));
        for (int i = 0; i < ed.size() && i < mon_q.size(); i++) begin
            chk({nm, "_dat"}, 32'(mon_q[i].dat), 32'(ed[i]));
            chk({nm, "_tid"}, 32'(mon_q[i].tid), 32'(et[i]));
            chk({nm, "_last"}, 32'(mon_q[i].last), 32'(i == ed.size() - 1 || et[i] != et[i+1]));
        end
    endtask

    // Packet plan per port for traffic runs.
    int plen [4][8];
    int pcnt [4];

    task automatic run_traffic(input int gap_pct, input int rdy_pct, input bit chk_gap);
        beat_t      exp_q[$];
        int         rem[4];
        int         pk[4];
        int         bt[4];
        int         ptr = 3;
        int         total = 0;
        int         budget = 0;
        logic [3:0] hs = '0;
        bit         v;
        // Model: every port with packets left is always requesting at arbitration time,
        // so packets leave in pure round-robin order starting after port 3.
        for (int p = 0; p < 4; p++) begin rem[p] = pcnt[p]; total += pcnt[p]; pk[p] = 0; bt[p] = 0; end
        for (int n = 0; n < total; n++) begin
            for (int k = 1; k <= 4; k++) begin
                int q = (ptr + k) % 4;
                if (rem[q] > 0) begin
                    int idx = pcnt[q] - rem[q];
                    for (int b = 0; b < plen[q][idx]; b++)
                        exp_q.push_back('{{2'(q), 6'(idx), 8'(b)}, b == plen[q][idx] - 1, 2'(q), 0});
                    rem[q]--;
                    ptr = q;
                    break;
                end
            end
        end
        mon_q.delete();
        mon_en = 1'b1;
        while (mon_q.size() < exp_q.size() && budget < 4000) begin
            for (int p = 0; p < 4; p++) begin
                if (hs[p]) begin
                    bt[p]++;
                    if (bt[p] == plen[p][pk[p]]) begin pk[p]++; bt[p] = 0; end
                end
                if (pk[p] >= pcnt[p])            v = 1'b0;
                else if (bt[p] == 0)             v = 1'b1;
                else if (s_tvalid[p] && !hs[p])  v = 1'b1;
                else                             v = ($urandom_range(99) >= gap_pct);
                s_tvalid[p] = v;
                if (pk[p] < pcnt[p]) begin
                    s_dat[p]   = {2'(p), 6'(pk[p]), 8'(bt[p])};
                    s_tlast[p] = (bt[p] == plen[p][pk[p]] - 1);
                end
            end
            m_tready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk); #1;
            budget++;
        end
        clear_inputs();
        m_tready = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("trf_count", 32'(mon_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk("trf_dat", 32'(mon_q[i].dat), 32'(exp_q[i].dat));
            chk("trf_last", 32'(mon_q[i].last), 32'(exp_q[i].last));
            chk("trf_tid", 32'(mon_q[i].tid), 32'(exp_q[i].tid));
            if (chk_gap && i > 0)
                chk("trf_spacing", 32'(mon_q[i].cyc - mon_q[i-1].cyc), exp_q[i-1].last ? 32'd2 : 32'd1);
        end
        chk("trf_pkt_count", 32'(pkt_count), 32'(total));
        if (total > 0) chk("trf_grant_id", 32'(grant_id), 32'(ptr));
    endtask

    typedef struct {
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic        mr;
        logic [3:0]  rdy;
        logic        mv;
        logic [15:0] dat;
        logic        last;
        logic [1:0]  tid;
        logic        ga;
        logic [1:0]  gid;
        logic [15:0] pkt;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        // Rows are consecutive cycles after reset release; port p drives data {p, row}.
        tbl[0]  = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 2'd3, 16'd0};
        tbl[1]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 2'd3, 16'd0};
        tbl[2]  = '{4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b1, 16'h3001, 1'b1, 2'd3, 1'b0, 2'd3, 16'd1};
        tbl[3]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 2'd3, 16'd1};
        tbl[4]  = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'h3003, 1'b1, 2'd3, 1'b0, 2'd3, 16'd2};
        tbl[5]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 2'd1, 16'd2};
        tbl[6]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 16'h1005, 1'b0, 2'd1, 1'b1, 2'd1, 16'd2};
        tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'h1005, 1'b0, 2'd1, 1'b1, 2'd1, 16'd2};
        tbl[8]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'h1005, 1'b0, 2'd1, 1'b1, 2'd1, 16'd2};
        tbl[9]  = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b1, 16'h1005, 1'b0, 2'd1, 1'b1, 2'd1, 16'd2};
        tbl[10] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 16'h1006, 1'b0, 2'd1, 1'b1, 2'd1, 16'd2};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'h100A, 1'b1, 2'd1, 1'b0, 2'd1, 16'd3};
        tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 2'd1, 16'd3};

        clear_inputs();
        @(negedge clk);
        chk("rst_rdy", 32'(s_tready), 32'd0);
        chk("rst_mvld", 32'(m_tvalid), 32'd0);
        chk("rst_mout", 32'({m_tlast, m_tid, m_tdata}), 32'd0);
        chk("rst_ga", 32'(grant_active), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd3);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            s_tvalid = tbl[i].tv;
            s_tlast  = tbl[i].tl;
            m_tready = tbl[i].mr;
            for (int p = 0; p < 4; p++) s_dat[p] = {4'(p), 12'(i)};
            @(negedge clk);
            chk("vec_rdy", 32'(s_tready), 32'(tbl[i].rdy));
            chk("vec_mvld", 32'(m_tvalid), 32'(tbl[i].mv));
            chk("vec_ga", 32'(grant_active), 32'(tbl[i].ga));
            chk("vec_gid", 32'(grant_id), 32'(tbl[i].gid));
            chk("vec_pkt", 32'(pkt_count), 32'(tbl[i].pkt));
            if (tbl[i].mv) begin
                chk("vec_dat", 32'(m_tdata), 32'(tbl[i].dat));
                chk("vec_last", 32'(m_tlast), 32'(tbl[i].last));
                chk("vec_tid", 32'(m_tid), 32'(tbl[i].tid));
            end
            @(posedge clk); #1;
        end

        // All four ports with 2-beat packets: order 0,1,2,3,0 and one bubble between packets.
        do_reset();
        for (int p = 0; p < 4; p++) begin pcnt[p] = (p == 0) ? 2 : 1; plen[p][0] = 2; plen[p][1] = 2; end
        run_traffic(0, 100, 1'b1);

        // Port 2 holds its grant for 5 beats while port 0 waits.
        do_reset();
        m_tready = 1'b1;
        mon_q.delete();
        mon_en = 1'b1;
        send_beat(2, 16'h2000, 1'b0);
        send_beat(2, 16'h2001, 1'b0);
        s_tvalid[0] = 1'b1; s_dat[0] = 16'h0000; s_tlast[0] = 1'b0;
        send_beat(2, 16'h2002, 1'b0);
        send_beat(2, 16'h2003, 1'b0);
        send_beat(2, 16'h2004, 1'b1);
        @(negedge clk);
        chk("hold_idle_ga", 32'(grant_active), 32'd0);
        chk("hold_idle_rdy0", 32'(s_tready[0]), 32'd0);
        @(posedge clk); #1;
        send_beat(0, 16'h0000, 1'b0);
        send_beat(0, 16'h0001, 1'b1);
        drain_and_check('{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 16'h0000, 16'h0001},
                        '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0}, "hold");
        chk("hold_gid", 32'(grant_id), 32'd0);

        // Port 1 stalls mid-packet while port 2 requests: grant must not move.
        do_reset();
        m_tready = 1'b1;
        mon_q.delete();
        mon_en = 1'b1;
        s_tvalid[2] = 1'b1; s_dat[2] = 16'h2100; s_tlast[2] = 1'b1;
        send_beat(1, 16'h1100, 1'b0);
        send_beat(1, 16'h1101, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("gap_gid", 32'(grant_id), 32'd1);
            chk("gap_ga", 32'(grant_active), 32'd1);
            chk("gap_rdy2", 32'(s_tready[2]), 32'd0);
            @(posedge clk); #1;
        end
        send_beat(1, 16'h1102, 1'b0);
        send_beat(1, 16'h1103, 1'b1);
        send_beat(2, 16'h2100, 1'b1);
        drain_and_check('{16'h1100, 16'h1101, 16'h1102, 16'h1103, 16'h2100},
                        '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2}, "gap");

        // Reset mid-packet with main and skid both loaded.
        do_reset();
        s_tvalid[1] = 1'b1; s_dat[1] = 16'h1200; s_tlast[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_mvld", 32'(m_tvalid), 32'd1);
        chk("full_rdy", 32'(s_tready), 32'd0);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_mvld", 32'(m_tvalid), 32'd0);
        chk("arst_gid", 32'(grant_id), 32'd3);
        chk("arst_ga", 32'(grant_active), 32'd0);
        chk("arst_pkt", 32'(pkt_count), 32'd0);
        chk("arst_rdy", 32'(s_tready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        s_tvalid = 4'b0101;
        @(negedge clk);
        chk("rel_ga", 32'(grant_active), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_gid", 32'(grant_id), 32'd0);
        chk("rel_ga2", 32'(grant_active), 32'd1);
        chk("rel_rdy", 32'(s_tready), 32'b0001);

        // Randomized packet mixes with gaps and downstream back-pressure.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int p = 0; p < 4; p++) begin
                pcnt[p] = $urandom_range(0, 5);
                for (int k = 0; k < 8; k++) plen[p][k] = $urandom_range(1, 5);
            end
            run_traffic(30, 65, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
